// File: rtl/inst_trace_axi_writer.sv
// inst_trace_axi_writer: captures PicoRV32 fetch addresses in a small FIFO and drains them
// as single-beat AXI4-lite writes into a word ring buffer in system memory.
module inst_trace_axi_writer #(
  parameter int INST_ADDR_WIDTH    = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic                            trace_en,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ring_base,
  input  logic [15:0]                     ring_words,
  input  logic                            ring_rst,
  input  logic                            drop_clr,
  input  logic                            inst_valid,
  input  logic [INST_ADDR_WIDTH-1:0]      inst_addr,
  output logic [15:0]                     wr_ptr,
  output logic [15:0]                     drop_cnt,
  output logic                            err,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = FIFO_DEPTH[CW-1:0];
  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;
  state_t state, state_nx;
  logic [INST_ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_idx, wr_idx;
  logic [CW-1:0] count;
  logic [15:0] words_q, ptr_eff, ptr_inc;
  logic [16:0] ptr_sum;
  logic capture, push, pop, drop, done, aw_nx, w_nx, rst_pend;
  assign capture = inst_valid && trace_en;
  assign pop = state == IDLE && count != '0 && ring_words != '0;
  assign push = capture && (count != FULL || pop);
  assign drop = capture && !push;
  assign done = state == RESP && m_axi_bvalid;
  assign aw_nx = m_axi_awvalid && !m_axi_awready;
  assign w_nx = m_axi_wvalid && !m_axi_wready;
  assign ptr_eff = ring_rst ? '0 : wr_ptr;
  assign ptr_sum = {1'b0, wr_ptr} + 17'd1;
  // >= rather than == so a pointer stranded past a shrunk ring wraps on the next completion
  assign ptr_inc = (rst_pend || ring_rst || ptr_sum >= {1'b0, words_q}) ? '0 : ptr_sum[15:0];
  assign busy = count != '0 || state != IDLE;
  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb = '1;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (pop ? ADDR_DATA : IDLE) :
               state == ADDR_DATA ? ((aw_nx || w_nx) ? ADDR_DATA : RESP) :
               (m_axi_bvalid ? IDLE : RESP);
  end
  always_ff @(posedge m_axi_aclk)
    if (push) mem[wr_idx] <= inst_addr;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) begin
      state <= IDLE;
      rd_idx <= '0;
      wr_idx <= '0;
      count <= '0;
      words_q <= '0;
      rst_pend <= 1'b0;
      wr_ptr <= '0;
      drop_cnt <= '0;
      err <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
    end else begin
      state <= state_nx;
      rd_idx <= rd_idx + AW'(pop);
      wr_idx <= wr_idx + AW'(push);
      count <= count + CW'(push) - CW'(pop);
      m_axi_awvalid <= pop || aw_nx;
      m_axi_wvalid <= pop || w_nx;
      m_axi_bready <= (state == ADDR_DATA && !aw_nx && !w_nx) || (state == RESP && !m_axi_bvalid);
      if (pop) begin
        m_axi_awaddr <= (ring_base & ~C_M_AXI_ADDR_WIDTH'(3)) + C_M_AXI_ADDR_WIDTH'({ptr_eff, 2'b00});
        m_axi_wdata <= C_M_AXI_DATA_WIDTH'(mem[rd_idx]);
        words_q <= ring_words;
      end
      if (state == IDLE && ring_rst) wr_ptr <= '0;
      else if (done) wr_ptr <= ptr_inc;
      rst_pend <= !done && (rst_pend || (ring_rst && state != IDLE));
      err <= !drop_clr && (err || (done && m_axi_bresp != 2'b00));
      drop_cnt <= drop_clr ? {15'd0, drop} : drop_cnt + {15'd0, drop && drop_cnt != 16'hFFFF};
    end
endmodule

// File: tb/tb_inst_trace_axi_writer.sv
// tb_inst_trace_axi_writer: directed stimulus with a write scoreboard checked by a separate monitor.
module tb_inst_trace_axi_writer;
  logic clk = 0, rst_n = 0;
  logic trace_en = 0, ring_rst = 0, drop_clr = 0, inst_valid = 0;
  logic [31:0] ring_base = 32'h8000_0000, inst_addr = 0;
  logic [15:0] ring_words = 16'd4;
  logic [15:0] wr_ptr, drop_cnt;
  logic err, busy;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [2:0] m_axi_awprot;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic m_axi_awready = 1, m_axi_wready = 1, m_axi_bvalid = 0;
  logic [1:0] m_axi_bresp = 0, bresp_knob = 0;
  logic b_hold = 0;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int errors = 0, checks = 0, exp_ptr = 0;

  always #5 clk = ~clk;

  inst_trace_axi_writer dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .trace_en(trace_en), .ring_base(ring_base),
    .ring_words(ring_words), .ring_rst(ring_rst), .drop_clr(drop_clr), .inst_valid(inst_valid),
    .inst_addr(inst_addr), .wr_ptr(wr_ptr), .drop_cnt(drop_cnt), .err(err), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] a, input bit keep);
    inst_valid = 1;
    inst_addr = a;
    if (keep) begin
      exp_q.push_back('{addr: ring_base + 32'(exp_ptr * 4), data: a});
      exp_ptr = (exp_ptr + 1) % 4;
    end
    step(1);
    inst_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin step(1); n++; end
    chk("idle_reached", busy, 0);
  endtask

  // memory-side write response: bvalid one cycle after bready, unless held off
  initial forever begin
    @(posedge clk); #1;
    m_axi_bvalid = m_axi_bready && !b_hold;
    m_axi_bresp = m_axi_bvalid ? bresp_knob : 2'b00;
  end

  initial begin
    logic got_aw, got_w;
    logic [31:0] a, d;
    wr_t e;
    got_aw = 0; got_w = 0; a = 0; d = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        got_aw = 0; got_w = 0;
      end else begin
        if (m_axi_awvalid && m_axi_awready && !got_aw) begin got_aw = 1; a = m_axi_awaddr; end
        if (m_axi_wvalid && m_axi_wready && !got_w) begin got_w = 1; d = m_axi_wdata; end
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", a, d);
          end else begin
            e = exp_q.pop_front();
            checks--;
            chk("sb_awaddr", a, e.addr);
            chk("sb_wdata", d, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    trace_en = 1;
    step(3);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("awprot", m_axi_awprot, 0);
    chk("wstrb", m_axi_wstrb, 4'hF);
    rst_n = 1;
    step(1);
    // single sample and issue latency
    send(32'h0000_1000, 1);
    chk("lat_edge_n", m_axi_awvalid, 0);
    step(1);
    chk("lat_awvalid", m_axi_awvalid, 1);
    chk("lat_wvalid", m_axi_wvalid, 1);
    chk("t1_awaddr", m_axi_awaddr, 32'h8000_0000);
    chk("t1_wdata", m_axi_wdata, 32'h0000_1000);
    wait_idle();
    chk("t1_wr_ptr", wr_ptr, 1);
    ring_rst = 1;
    step(1);
    ring_rst = 0;
    exp_ptr = 0;
    chk("ring_rst_idle", wr_ptr, 0);
    // wrap
    for (int i = 0; i < 5; i++) send(32'h2000 + 32'(i * 4), 1);
    wait_idle();
    chk("wrap_wr_ptr", wr_ptr, 1);
    chk("wrap_drained", exp_q.size(), 0);
    // overflow with awready held low
    m_axi_awready = 0;
    for (int i = 0; i < 12; i++) send(32'h3000 + 32'(i * 4), i < 9);
    chk("ovf_drop_cnt", drop_cnt, 3);
    chk("ovf_busy", busy, 1);
    m_axi_awready = 1;
    wait_idle();
    chk("ovf_drop_kept", drop_cnt, 3);
    chk("ovf_drained", exp_q.size(), 0);
    // ring_words=0: no issue, fill, drop, drop+clear in one cycle
    ring_words = 0;
    for (int i = 0; i < 8; i++) send(32'h4000 + 32'(i * 4), 1);
    chk("rw0_no_issue", m_axi_awvalid, 0);
    send(32'h4100, 0);
    chk("rw0_drop", drop_cnt, 4);
    drop_clr = 1;
    send(32'h4104, 0);
    drop_clr = 0;
    chk("drop_and_clr", drop_cnt, 1);
    ring_words = 4;
    wait_idle();
    chk("rw0_drained", exp_q.size(), 0);
    // channel skew: data first, then address first
    m_axi_awready = 0;
    m_axi_wready = 0;
    send(32'h5000, 1);
    step(1);
    chk("skew1_aw", m_axi_awvalid, 1);
    m_axi_wready = 1;
    step(1);
    chk("skew1_wdrop", m_axi_wvalid, 0);
    chk("skew1_awhold", m_axi_awvalid, 1);
    chk("skew1_nob", m_axi_bready, 0);
    m_axi_wready = 0;
    step(2);
    chk("skew1_awhold2", m_axi_awvalid, 1);
    chk("skew1_nob2", m_axi_bready, 0);
    m_axi_awready = 1;
    step(1);
    chk("skew1_awdrop", m_axi_awvalid, 0);
    chk("skew1_bready", m_axi_bready, 1);
    wait_idle();
    send(32'h5004, 1);
    step(1);
    chk("skew2_aw", m_axi_awvalid, 1);
    step(1);
    chk("skew2_awdrop", m_axi_awvalid, 0);
    chk("skew2_whold", m_axi_wvalid, 1);
    chk("skew2_nob", m_axi_bready, 0);
    step(1);
    chk("skew2_nob2", m_axi_bready, 0);
    m_axi_wready = 1;
    step(1);
    chk("skew2_wdrop", m_axi_wvalid, 0);
    chk("skew2_bready", m_axi_bready, 1);
    wait_idle();
    chk("skew_drained", exp_q.size(), 0);
    // error response and clear
    bresp_knob = 2'b10;
    send(32'h6000, 1);
    wait_idle();
    chk("err_set", err, 1);
    bresp_knob = 2'b00;
    send(32'h6004, 1);
    wait_idle();
    chk("err_sticky", err, 1);
    drop_clr = 1;
    step(1);
    drop_clr = 0;
    chk("err_clr", err, 0);
    chk("drop_clr", drop_cnt, 0);
    // reset while waiting for the write response
    b_hold = 1;
    send(32'h7000, 1);
    send(32'h7004, 0);
    n = 0;
    while (!m_axi_bready && n < 20) begin step(1); n++; end
    chk("resp_reached", m_axi_bready, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_awvalid", m_axi_awvalid, 0);
    chk("arst_wvalid", m_axi_wvalid, 0);
    chk("arst_bready", m_axi_bready, 0);
    chk("arst_awaddr", m_axi_awaddr, 0);
    chk("arst_wdata", m_axi_wdata, 0);
    chk("arst_wr_ptr", wr_ptr, 0);
    chk("arst_busy", busy, 0);
    b_hold = 0;
    step(2);
    rst_n = 1;
    exp_ptr = 0;
    step(3);
    chk("post_rst_empty", m_axi_awvalid, 0);
    chk("post_rst_busy", busy, 0);
    send(32'h7100, 1);
    wait_idle();
    chk("post_rst_wr_ptr", wr_ptr, 1);
    chk("final_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
